// File: rtl/fbw_arbiter.sv
// fbw_arbiter: shares one frame buffer write port between two row-oriented
// pattern sources. Ownership changes only at frame boundaries, alternates
// round-robin, and an owner keeps at most MAX_FRAMES frames while the other
// source is waiting. Every hand-over passes through one idle cycle.
module fbw_arbiter #(
    parameter int MAX_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        s0_req,
    output logic        s0_grant,
    input  logic [5:0]  s0_row_addr,
    input  logic        s0_row_store,
    input  logic        s0_row_swap,
    output logic        s0_row_rdy,
    input  logic [23:0] s0_data,
    input  logic [5:0]  s0_col_addr,
    input  logic        s0_wren,
    input  logic        s0_frame_swap,
    output logic        s0_frame_rdy,

    input  logic        s1_req,
    output logic        s1_grant,
    input  logic [5:0]  s1_row_addr,
    input  logic        s1_row_store,
    input  logic        s1_row_swap,
    output logic        s1_row_rdy,
    input  logic [23:0] s1_data,
    input  logic [5:0]  s1_col_addr,
    input  logic        s1_wren,
    input  logic        s1_frame_swap,
    output logic        s1_frame_rdy,

    output logic [5:0]  m_row_addr,
    output logic        m_row_store,
    output logic        m_row_swap,
    output logic [23:0] m_data,
    output logic [5:0]  m_col_addr,
    output logic        m_wren,
    output logic        m_frame_swap,
    input  logic        m_row_rdy,
    input  logic        m_frame_rdy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    localparam logic [8:0] MAX_W9 = 9'(MAX_FRAMES);
    localparam logic [7:0] MAX_W8 = 8'(MAX_FRAMES);

    state_t     state;
    state_t     next_state;
    logic       rr_last;
    logic [7:0] fcnt;
    logic       frame_open;

    logic       own_req;
    logic       oth_req;
    logic       own_act;
    logic       own_fswap;
    logic [8:0] fcnt_inc;

    assign fcnt_inc = {1'b0, fcnt} + 9'd1;

    // Owner-relative view of the request and frame-activity inputs.
    always_comb begin
        own_req   = 1'b0;
        oth_req   = 1'b0;
        own_act   = 1'b0;
        own_fswap = 1'b0;
        case (state)
            ST_GRANT0: begin
                own_req   = s0_req;
                oth_req   = s1_req;
                own_act   = s0_wren | s0_row_store | s0_row_swap;
                own_fswap = s0_frame_swap;
            end
            ST_GRANT1: begin
                own_req   = s1_req;
                oth_req   = s0_req;
                own_act   = s1_wren | s1_row_store | s1_row_swap;
                own_fswap = s1_frame_swap;
            end
            default: ;
        endcase
    end

    // Next-state: round-robin pick from idle, release only at frame edges
    // or when the owner has left with no frame in progress.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (s0_req && s1_req)
                    next_state = rr_last ? ST_GRANT0 : ST_GRANT1;
                else if (s0_req)
                    next_state = ST_GRANT0;
                else if (s1_req)
                    next_state = ST_GRANT1;
            end
            ST_GRANT0, ST_GRANT1: begin
                if ((own_fswap && (!own_req || (oth_req && (fcnt_inc >= MAX_W9)))) ||
                    (!own_req && !frame_open))
                    next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output steering: the owner sees the frame buffer, everyone else sees 0.
    always_comb begin
        m_row_addr   = '0;
        m_row_store  = 1'b0;
        m_row_swap   = 1'b0;
        m_data       = '0;
        m_col_addr   = '0;
        m_wren       = 1'b0;
        m_frame_swap = 1'b0;
        s0_grant     = 1'b0;
        s0_row_rdy   = 1'b0;
        s0_frame_rdy = 1'b0;
        s1_grant     = 1'b0;
        s1_row_rdy   = 1'b0;
        s1_frame_rdy = 1'b0;
        case (state)
            ST_GRANT0: begin
                m_row_addr   = s0_row_addr;
                m_row_store  = s0_row_store;
                m_row_swap   = s0_row_swap;
                m_data       = s0_data;
                m_col_addr   = s0_col_addr;
                m_wren       = s0_wren;
                m_frame_swap = s0_frame_swap;
                s0_grant     = 1'b1;
                s0_row_rdy   = m_row_rdy;
                s0_frame_rdy = m_frame_rdy;
            end
            ST_GRANT1: begin
                m_row_addr   = s1_row_addr;
                m_row_store  = s1_row_store;
                m_row_swap   = s1_row_swap;
                m_data       = s1_data;
                m_col_addr   = s1_col_addr;
                m_wren       = s1_wren;
                m_frame_swap = s1_frame_swap;
                s1_grant     = 1'b1;
                s1_row_rdy   = m_row_rdy;
                s1_frame_rdy = m_frame_rdy;
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Grant bookkeeping: fresh counters on each new grant, frame tracking
    // and saturating frame count while owned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last    <= 1'b1;
            fcnt       <= '0;
            frame_open <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (next_state != ST_IDLE) begin
                rr_last    <= (next_state == ST_GRANT1);
                fcnt       <= '0;
                frame_open <= 1'b0;
            end
        end else begin
            if (own_fswap) begin
                fcnt       <= (fcnt_inc >= MAX_W9) ? MAX_W8 : fcnt_inc[7:0];
                frame_open <= 1'b0;
            end else if (own_act) begin
                frame_open <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fbw_arbiter.md
Name: fbw_arbiter

Overview:
- Shares one frame buffer write interface between two row-oriented pattern sources, s0 and s1.
- Each source uses the row/frame handshake that pgen drives.
- Sits between the sources and the frame buffer write port.
- Grants ownership at frame granularity with round-robin fairness and a per-grant frame quota.
- Never interleaves two sources inside one frame.

Parameters:
- MAX_FRAMES, 4, number of consecutive frames the owner keeps when the other source is requesting. Range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- sN_req  in  1  source N wants the frame buffer (N = 0, 1; the same set exists for each source)
- sN_grant  out  1  source N currently owns the write port
- sN_row_addr  in  6  row address from source N
- sN_row_store  in  1  row store request from source N
- sN_row_swap  in  1  row swap request from source N
- sN_row_rdy  out  1  frame buffer row-ready, gated to the owner
- sN_data  in  24  pixel data from source N
- sN_col_addr  in  6  column address from source N
- sN_wren  in  1  pixel write enable from source N
- sN_frame_swap  in  1  end-of-frame pulse from source N
- sN_frame_rdy  out  1  frame buffer frame-ready, gated to the owner
- m_row_addr, m_row_store, m_row_swap, m_data, m_col_addr, m_wren, m_frame_swap  out  6/1/1/24/6/1/1  to the frame buffer
- m_row_rdy  in  1  row ready from the frame buffer
- m_frame_rdy  in  1  frame ready from the frame buffer

Behaviour:
- State machine states: ST_IDLE, ST_GRANT0, ST_GRANT1. State is registered.
- Registered signals:
  - rr_last: last source granted. Reset value 1, so s0 wins the first tie.
  - fcnt[7:0]: frames completed in the current grant, saturating at MAX_FRAMES.
  - frame_open: set while a frame is in progress.
- Reset (asynchronous, takes effect immediately):
  - state goes to ST_IDLE, fcnt=0, frame_open=0, rr_last=1.
  - All outputs read 0.
- ST_IDLE:
  - All m_* outputs are 0. All sN_row_rdy, sN_frame_rdy and sN_grant are 0.
  - If only one source requests, go to that source's GRANT state.
  - If both request, grant the source that is not rr_last.
  - The grant is visible the cycle after the request is sampled in ST_IDLE.
  - Entering a GRANT state sets rr_last to that source and clears fcnt and frame_open.
- ST_GRANTn:
  - sN_grant=1 for the owner only.
  - All m_* outputs equal the owner's sN_* inputs, combinationally with zero latency.
  - Owner's sN_row_rdy = m_row_rdy and sN_frame_rdy = m_frame_rdy.
  - The non-owner's ready and grant outputs are held at 0, and all of its inputs are ignored.
- frame_open:
  - Set on any owner wren, row_store or row_swap.
  - Cleared on owner frame_swap; the clear wins if both occur in the same cycle.
- fcnt increments on owner frame_swap and saturates at MAX_FRAMES.
- Release is evaluated only on an owner frame_swap cycle. Next state is ST_IDLE if either holds:
  - owner req=0, or
  - other req=1 and fcnt+1 >= MAX_FRAMES.
- Also release when owner req=0 and frame_open=0, in any cycle; next state is ST_IDLE.
- Owner req dropping with frame_open=1: the grant is held until the owner's frame_swap completes the frame.
- If the other source does not request, the owner keeps the grant indefinitely and fcnt saturates.
- Every hand-over passes through exactly one ST_IDLE cycle, with all m_* outputs at 0 in that cycle.
- A source that raises req while it is already owner sees no effect.
- A source that raises req during the other's grant waits for that owner to release.
- Requests may stay asserted across grants.

Test Plan:
- Reset, then s0_req=1 at cycle 0 with s1_req=0 -> s0_grant=1 from cycle 1. m_data follows s0_data=0x123456 combinationally. s1_grant=0.
- s0_req=s1_req=1 from reset, MAX_FRAMES=4, s0 issues 4 frame_swap pulses:
  - Grant order is s0 first; s0 keeps the grant until its 4th swap.
  - One ST_IDLE cycle follows with all m_* at 0.
  - s1_grant=1 on the next cycle.
  - After s1 completes 4 frames, the grant returns to s0.
- s0 alone requests and completes 10 frames -> s0_grant is never deasserted, no IDLE bubble, fcnt saturates at 4.
- s0 drops req right after its first wren of a frame (frame_open=1) -> grant is held until s0_frame_swap, then ST_IDLE. Separately, s0 drops req with frame_open=0 -> ST_IDLE on the next cycle.
- Isolation: while s0 is owner, drive s1_wren=1, s1_data=0xABCDEF, m_row_rdy=1, m_frame_rdy=1:
  - m_wren and m_data follow s0 only.
  - s1_row_rdy=0 and s1_frame_rdy=0.
  - s0_row_rdy=1 and s0_frame_rdy=1.
- Assert rst mid-frame during ST_GRANT1 -> all outputs are 0 in the same cycle, without waiting for a clock edge. After release with both sources requesting, s0 is granted first.
